// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add multiplier controller: 32-bit sample x CW-bit unsigned coefficient, using one external left barrel shifter.
// Latency: result valid max(popcount(coef),1)+1 cycles after the command is accepted; one add per set coefficient bit.
// Backpressure: start_ready only in IDLE; the result is held stable in DONE until res_ready, and start_valid is ignored while busy.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start_valid/start_ready  command handshake carrying a_in (32b) and coef_in (CW bits)
//   res_valid/res_ready      result handshake carrying result (product mod 2^32) and overflow
//   busy                     high while an operation is scanning or holding its result
//   sh_a, sh_s, sh_y         external shifter operand, shift amount and combinational result
module shift_add_mult_ctrl #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [31:0]   a_in,
    input  logic [CW-1:0] coef_in,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   result,
    output logic          overflow,
    output logic          busy,
    output logic [31:0]   sh_a,
    output logic [4:0]    sh_s,
    input  logic [31:0]   sh_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] acc;
    logic [31:0] a_reg;
    logic [31:0] coef_rem;
    logic        ovf;

    logic [4:0]  k;
    logic [31:0] coef_clr;
    logic [32:0] sum;
    logic        shift_out;
    logic        coef_nz;

    // Lowest set bit of the remaining coefficient; scanning from the top
    // down lets the lowest index overwrite any higher one.
    always_comb begin
        k = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (coef_rem[i]) begin
                k = 5'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit, i.e. bit k.
    assign coef_clr  = coef_rem & (coef_rem - 32'd1);
    assign coef_nz   = (coef_rem != 32'd0);
    assign sum       = {1'b0, acc} + {1'b0, sh_y};
    // Top k bits of a_reg are lost by a left shift of k.
    assign shift_out = (k != 5'd0) && ((a_reg & ~(32'hFFFF_FFFF >> k)) != 32'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and shifter drive
    always_comb begin
        state_nxt = state;
        sh_a      = 32'd0;
        sh_s      = 5'd0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                sh_a = a_reg;
                sh_s = k;
                // A zero coefficient still spends one SCAN cycle, then finishes.
                if (coef_clr == 32'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= 32'd0;
            a_reg    <= 32'd0;
            coef_rem <= 32'd0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg    <= a_in;
                        coef_rem <= 32'(coef_in);
                        acc      <= 32'd0;
                        ovf      <= 1'b0;
                    end
                end
                SCAN: begin
                    if (coef_nz) begin
                        acc      <= sum[31:0];
                        coef_rem <= coef_clr;
                        if (sum[32] || shift_out) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign start_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign res_valid   = (state == DONE);
    assign result      = (state == DONE) ? acc : 32'd0;
    assign overflow    = (state == DONE) ? ovf : 1'b0;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [31:0]   a_in;
    logic [CW-1:0] coef_in;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   result;
    logic          overflow;
    logic          busy;
    logic [31:0]   sh_a;
    logic [4:0]    sh_s;
    logic [31:0]   sh_y;

    shift_add_mult_ctrl #(.CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .coef_in     (coef_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .overflow    (overflow),
        .busy        (busy),
        .sh_a        (sh_a),
        .sh_s        (sh_s),
        .sh_y        (sh_y)
    );

    always #5 clk = ~clk;

    // External barrel shifter
    assign sh_y = sh_a << sh_s;

    int tests = 0;
    int fails = 0;
    logic [32:0] expq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: full-precision product; overflow means it needs more than 32 bits.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [CW-1:0] c);
        logic [63:0] p;
        p = 64'(a) * 64'(c);
        return {(p[63:32] != 32'd0), p[31:0]};
    endfunction

    // Scoreboard monitor: compares on every result handshake
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %0h with no command pending", result);
            end else begin
                logic [32:0] e;
                e = expq.pop_front();
                chk("result", 64'(result), 64'(e[31:0]));
                chk("overflow", 64'(overflow), 64'(e[32]));
            end
        end
    end

    task automatic cmd(input logic [31:0] a, input logic [CW-1:0] c, input int hold);
        int          n;
        int          cyc;
        int          p;
        logic [4:0]  got[$];
        int          want[$];
        logic [31:0] r0;
        logic        o0;
        for (int i = 0; i < CW; i++) begin
            if (c[i]) want.push_back(i);
        end
        if (want.size() == 0) want.push_back(0);
        p = want.size();

        start_valid = 1'b1;
        a_in        = a;
        coef_in     = c;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: start_ready stayed 0 for %0d cycles", n);
            start_valid = 1'b0;
            return;
        end
        expq.push_back(model(a, c));
        @(posedge clk);
        #1;
        // Noise on the command port while busy must be ignored.
        start_valid = 1'($urandom_range(0, 1));
        a_in        = $urandom;
        coef_in     = CW'($urandom);

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!res_valid) got.push_back(sh_s);
        end while (!res_valid && cyc < 60);
        chk("latency", 64'(cyc), 64'(p + 1));
        chk("shift_count", 64'(got.size()), 64'(p));
        for (int i = 0; i < got.size() && i < want.size(); i++) begin
            chk("sh_s_seq", 64'(got[i]), 64'(want[i]));
        end

        r0 = result;
        o0 = overflow;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            start_valid = 1'b1;
            a_in        = $urandom;
            @(negedge clk);
            chk("hold_result", 64'(result), 64'(r0));
            chk("hold_overflow", 64'(overflow), 64'(o0));
            chk("hold_start_ready", 64'(start_ready), 64'd0);
            chk("hold_valid", 64'(res_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("idle_start_ready", 64'(start_ready), 64'd1);
        chk("valid_dropped", 64'(res_valid), 64'd0);
        chk("idle_sh_s", 64'(sh_s), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        a_in        = 32'd0;
        coef_in     = '0;
        res_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_sh_a", 64'(sh_a), 64'd0);
        chk("rst_sh_s", 64'(sh_s), 64'd0);
        chk("rst_start_ready", 64'(start_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_start_ready", 64'(start_ready), 64'd1);
        @(posedge clk);
        #1;

        cmd(32'd5, 16'h000A, 0);
        cmd(32'd123, 16'h0000, 1);
        cmd(32'hFFFF_FFFF, 16'h0003, 0);
        cmd(32'd1, 16'hFFFF, 2);
        cmd(32'h0000_DEAD, 16'h1234, 5);

        // Reset in the middle of a scan aborts the command without a result.
        start_valid = 1'b1;
        a_in        = 32'h0000_1234;
        coef_in     = 16'h00F0;
        @(negedge clk);
        chk("abort_accept_ready", 64'(start_ready), 64'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sh_s", 64'(sh_s), 64'd0);
        chk("abort_sh_a", 64'(sh_a), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_start_ready", 64'(start_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd(32'd7, 16'h00F0, 1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0]   a;
            logic [CW-1:0] c;
            a = $urandom;
            c = CW'($urandom);
            if (i % 3 == 0) c = c & CW'($urandom);
            if (i % 4 == 0) a = $urandom_range(0, 255);
            if (i % 7 == 0) c = '0;
            cmd(a, c, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
